// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, fetches words over req/ack into a small
// prefetch FIFO and hands them to decode; redirects flush wrong-path words.
module instr_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [5:0]        instr_opcode
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic {
        FETCH,
        DROP
    } fetchStateT;

    fetchStateT        state;
    logic [ADDR_W-1:0] pendPc;
    logic [31:0]       fifoWord [DEPTH];
    logic [ADDR_W-1:0] fifoPc [DEPTH];
    logic [PW-1:0]     wrPtr;
    logic [PW-1:0]     rdPtr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     occNext;
    logic              transfer;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] target;
    logic              unusedPcBits;

    assign target       = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign unusedPcBits = ^redirect_pc[1:0];

    assign transfer = imem_req && imem_ack;
    assign push     = transfer && (state == FETCH) && !redirect;
    assign pop      = instr_valid && instr_ready;
    assign occNext  = count + CW'(push) - CW'(pop);

    assign instr_valid  = (count != '0);
    assign instr        = instr_valid ? fifoWord[rdPtr] : '0;
    assign instr_pc     = instr_valid ? fifoPc[rdPtr] : '0;
    assign instr_opcode = instr[31:26];

    // A request is only raised when the word it returns is guaranteed a slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FETCH;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            pendPc    <= RESET_PC;
        end else if (redirect) begin
            pendPc <= target;
            if (imem_req && !imem_ack) begin
                state <= DROP;
            end else begin
                state     <= FETCH;
                imem_req  <= 1'b1;
                imem_addr <= target;
            end
        end else begin
            unique case (state)
                DROP: begin
                    if (imem_ack) begin
                        state     <= FETCH;
                        imem_addr <= pendPc;
                    end
                end
                default: begin
                    if (transfer) begin
                        imem_addr <= imem_addr + ADDR_W'(4);
                    end
                    imem_req <= (occNext < CW'(DEPTH));
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (redirect) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + PW'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PW'(1);
            end
            count <= occNext;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifoWord[wrPtr] <= imem_rdata;
            fifoPc[wrPtr]   <= imem_addr;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: expected pcs are queued by each
// scenario and popped whenever decode accepts a head word.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemRdata;
    logic        redirect;
    logic [31:0] redirectPc;
    logic        instrValid;
    logic        instrReady;
    logic [31:0] instr;
    logic [31:0] instrPc;
    logic [5:0]  instrOpcode;

    logic        rst2N;
    logic        imemReq2;
    logic [31:0] imemAddr2;
    logic        imemAck2;
    logic [31:0] imemRdata2;
    logic        redirect2;
    logic [31:0] redirectPc2;
    logic        instrValid2;
    logic        instrReady2;
    logic [31:0] instr2;
    logic [31:0] instrPc2;
    logic [5:0]  instrOpcode2;

    int          checks;
    int          passed;
    int          ackLat;
    int          waitCnt;
    logic [31:0] expQ[$];

    instr_fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imemReq),
        .imem_addr    (imemAddr),
        .imem_ack     (imemAck),
        .imem_rdata   (imemRdata),
        .redirect     (redirect),
        .redirect_pc  (redirectPc),
        .instr_valid  (instrValid),
        .instr_ready  (instrReady),
        .instr        (instr),
        .instr_pc     (instrPc),
        .instr_opcode (instrOpcode)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dutWrap (
        .clk          (clk),
        .rst_n        (rst2N),
        .imem_req     (imemReq2),
        .imem_addr    (imemAddr2),
        .imem_ack     (imemAck2),
        .imem_rdata   (imemRdata2),
        .redirect     (redirect2),
        .redirect_pc  (redirectPc2),
        .instr_valid  (instrValid2),
        .instr_ready  (instrReady2),
        .instr        (instr2),
        .instr_pc     (instrPc2),
        .instr_opcode (instrOpcode2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: mem[a] = a << 8, ack after ackLat waiting cycles.
    initial begin
        imemAck   = 1'b0;
        imemRdata = '0;
        waitCnt   = 0;
        forever begin
            @(negedge clk);
            if (imemReq && waitCnt >= ackLat) begin
                imemAck   = 1'b1;
                imemRdata = imemAddr << 8;
                waitCnt   = 0;
            end else begin
                imemAck   = 1'b0;
                imemRdata = '0;
                waitCnt   = imemReq ? waitCnt + 1 : 0;
            end
        end
    end

    initial begin
        imemAck2   = 1'b0;
        imemRdata2 = '0;
        forever begin
            @(negedge clk);
            imemAck2   = imemReq2;
            imemRdata2 = imemReq2 ? (imemAddr2 << 8) : '0;
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        redirect = 1'b0;
        expQ.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (imemReq !== 1'b0 || instrValid !== 1'b0) begin
            $display("FAIL reset_async: req=%b valid=%b want 0 0", imemReq, instrValid);
        end else passed++;
        checks++;
        if (imemAddr !== 32'h0 || instr !== 32'h0 || instrPc !== 32'h0) begin
            $display("FAIL reset_regs: addr=%h instr=%h pc=%h want 0", imemAddr, instr, instrPc);
        end else passed++;
        repeat (2) @(negedge clk);
        checks++;
        if (imemReq !== 1'b0) begin
            $display("FAIL reset_hold: req=%b want 0", imemReq);
        end else passed++;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (imemReq !== 1'b1 || imemAddr !== 32'h0 || instrValid !== 1'b0) begin
            $display("FAIL reset_first_req: req=%b addr=%h valid=%b want 1 0 0",
                     imemReq, imemAddr, instrValid);
        end else passed++;
    endtask

    task automatic test_stream();
        logic [31:0] expPc;
        logic [31:0] expWord;
        ackLat     = 0;
        instrReady = 1'b1;
        apply_reset();
        for (int k = 0; k < 8; k++) expQ.push_back(32'(4 * k));
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (i == 1) begin
                checks++;
                if (imemReq !== 1'b1 || imemAddr !== 32'h0) begin
                    $display("FAIL stream_c1: req=%b addr=%h want 1 0", imemReq, imemAddr);
                end else passed++;
            end
            if (instrValid && instrReady) begin
                checks++;
                if (expQ.size() == 0) begin
                    $display("FAIL stream_extra: pc=%h not expected", instrPc);
                end else begin
                    expPc   = expQ.pop_front();
                    expWord = expPc << 8;
                    if (instrPc !== expPc || instr !== expWord ||
                        instrOpcode !== expWord[31:26]) begin
                        $display("FAIL stream_word: pc=%h instr=%h op=%h want %h %h %h",
                                 instrPc, instr, instrOpcode, expPc, expWord, expWord[31:26]);
                    end else passed++;
                end
            end
        end
        checks++;
        if (expQ.size() != 0) begin
            $display("FAIL stream_rate: %0d words missing want 0", expQ.size());
        end else passed++;
    endtask

    task automatic test_backpressure();
        logic [31:0] expPc;
        ackLat     = 0;
        instrReady = 1'b0;
        apply_reset();
        for (int k = 0; k < 4; k++) expQ.push_back(32'(4 * k));
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            if (i == 4) begin
                checks++;
                if (imemReq !== 1'b0 || imemAddr !== 32'h8 ||
                    instrValid !== 1'b1 || instrPc !== 32'h0) begin
                    $display("FAIL bp_full: req=%b addr=%h valid=%b pc=%h want 0 8 1 0",
                             imemReq, imemAddr, instrValid, instrPc);
                end else passed++;
                instrReady = 1'b1;
            end
            if (instrValid && instrReady) begin
                checks++;
                if (expQ.size() == 0) begin
                    $display("FAIL bp_extra: pc=%h not expected", instrPc);
                end else begin
                    expPc = expQ.pop_front();
                    if (instrPc !== expPc || instr !== (expPc << 8)) begin
                        $display("FAIL bp_word: pc=%h instr=%h want %h", instrPc, instr, expPc);
                    end else passed++;
                end
            end
        end
        checks++;
        if (expQ.size() != 0) begin
            $display("FAIL bp_resume: %0d words missing want 0", expQ.size());
        end else passed++;
    endtask

    task automatic test_drop();
        logic [31:0] expPc;
        ackLat     = 3;
        instrReady = 1'b1;
        apply_reset();
        expQ.push_back(32'h40);
        expQ.push_back(32'h44);
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            redirect = (i == 1);
            redirectPc = (i == 1) ? 32'h40 : 32'h0;
            if (i >= 2 && i <= 4) begin
                checks++;
                if (imemReq !== 1'b1 || imemAddr !== 32'h0) begin
                    $display("FAIL drop_hold: req=%b addr=%h want 1 0", imemReq, imemAddr);
                end else passed++;
            end
            if (i == 5) begin
                checks++;
                if (imemReq !== 1'b1 || imemAddr !== 32'h40) begin
                    $display("FAIL drop_target: req=%b addr=%h want 1 40", imemReq, imemAddr);
                end else passed++;
            end
            if (instrValid && instrReady) begin
                checks++;
                if (expQ.size() == 0) begin
                    $display("FAIL drop_extra: pc=%h not expected", instrPc);
                end else begin
                    expPc = expQ.pop_front();
                    if (instrPc !== expPc || instr !== (expPc << 8)) begin
                        $display("FAIL drop_word: pc=%h instr=%h want %h", instrPc, instr, expPc);
                    end else passed++;
                end
            end
        end
        redirect = 1'b0;
        checks++;
        if (expQ.size() != 0) begin
            $display("FAIL drop_missing: %0d words missing want 0", expQ.size());
        end else passed++;
    endtask

    task automatic test_redirect_ack();
        logic [31:0] expPc;
        ackLat     = 0;
        instrReady = 1'b1;
        apply_reset();
        expQ = '{32'h0, 32'h4, 32'h8, 32'h100, 32'h104};
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            redirect = (i == 4);
            redirectPc = (i == 4) ? 32'h100 : 32'h0;
            if (i == 4) begin
                checks++;
                if (imemAck !== 1'b1 || instrValid !== 1'b1) begin
                    $display("FAIL rda_setup: ack=%b valid=%b want 1 1", imemAck, instrValid);
                end else passed++;
            end
            if (i == 5) begin
                checks++;
                if (instrValid !== 1'b0 || imemReq !== 1'b1 || imemAddr !== 32'h100) begin
                    $display("FAIL rda_flush: valid=%b req=%b addr=%h want 0 1 100",
                             instrValid, imemReq, imemAddr);
                end else passed++;
            end
            if (instrValid && instrReady) begin
                checks++;
                if (expQ.size() == 0) begin
                    $display("FAIL rda_extra: pc=%h not expected", instrPc);
                end else begin
                    expPc = expQ.pop_front();
                    if (instrPc !== expPc || instr !== (expPc << 8)) begin
                        $display("FAIL rda_word: pc=%h instr=%h want %h", instrPc, instr, expPc);
                    end else passed++;
                end
            end
        end
        redirect = 1'b0;
        checks++;
        if (expQ.size() != 0) begin
            $display("FAIL rda_missing: %0d words missing want 0", expQ.size());
        end else passed++;
    endtask

    task automatic test_async_reset();
        logic [31:0] expPc;
        ackLat     = 0;
        instrReady = 1'b1;
        apply_reset();
        expQ.push_back(32'h0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (imemReq !== 1'b0 || instrValid !== 1'b0) begin
            $display("FAIL midreset: req=%b valid=%b want 0 0", imemReq, instrValid);
        end else passed++;
        expQ.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        expQ.push_back(32'h0);
        expQ.push_back(32'h4);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            if (i == 1) begin
                checks++;
                if (imemReq !== 1'b1 || imemAddr !== 32'h0) begin
                    $display("FAIL midreset_restart: req=%b addr=%h want 1 0", imemReq, imemAddr);
                end else passed++;
            end
            if (instrValid && instrReady) begin
                checks++;
                if (expQ.size() == 0) begin
                    $display("FAIL midreset_extra: pc=%h not expected", instrPc);
                end else begin
                    expPc = expQ.pop_front();
                    if (instrPc !== expPc || instr !== (expPc << 8)) begin
                        $display("FAIL midreset_word: pc=%h instr=%h want %h", instrPc, instr, expPc);
                    end else passed++;
                end
            end
        end
        checks++;
        if (expQ.size() != 0) begin
            $display("FAIL midreset_missing: %0d words missing want 0", expQ.size());
        end else passed++;
    endtask

    task automatic test_wrap();
        logic [31:0] expPc;
        instrReady2 = 1'b1;
        expQ = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h10};
        @(negedge clk);
        checks++;
        if (imemAddr2 !== 32'hFFFF_FFF8 || imemReq2 !== 1'b0) begin
            $display("FAIL wrap_reset: addr=%h req=%b want fffffff8 0", imemAddr2, imemReq2);
        end else passed++;
        rst2N = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            redirect2 = (i == 5);
            redirectPc2 = (i == 5) ? 32'h13 : 32'h0;
            if (i == 6) begin
                checks++;
                if (imemReq2 !== 1'b1 || imemAddr2 !== 32'h10 || instrValid2 !== 1'b0) begin
                    $display("FAIL wrap_redirect: req=%b addr=%h valid=%b want 1 10 0",
                             imemReq2, imemAddr2, instrValid2);
                end else passed++;
            end
            if (instrValid2 && instrReady2) begin
                checks++;
                if (expQ.size() == 0) begin
                    $display("FAIL wrap_extra: pc=%h not expected", instrPc2);
                end else begin
                    expPc = expQ.pop_front();
                    if (instrPc2 !== expPc || instr2 !== (expPc << 8)) begin
                        $display("FAIL wrap_word: pc=%h instr=%h want %h", instrPc2, instr2, expPc);
                    end else passed++;
                end
            end
        end
        redirect2 = 1'b0;
        checks++;
        if (expQ.size() != 0) begin
            $display("FAIL wrap_missing: %0d words missing want 0", expQ.size());
        end else passed++;
    endtask

    initial begin
        checks      = 0;
        passed      = 0;
        ackLat      = 0;
        rst_n       = 1'b1;
        redirect    = 1'b0;
        redirectPc  = '0;
        instrReady  = 1'b0;
        rst2N       = 1'b0;
        redirect2   = 1'b0;
        redirectPc2 = '0;
        instrReady2 = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_drop();
        test_redirect_ack();
        test_async_reset();
        test_wrap();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
